fetch_unit: RTL

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_unit.sv | 129 ++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// Instruction fetch: FETCH -> HOLD -> EXEC loop, min 3 cycles/instr; imem_req held until ack, instr held until ready.
// Optional perf counters built only when FETCH_PERF_CNT_EN is defined.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [31:0] pc_out,
  input  logic        resolve_valid,
  input  logic        branch,
  input  logic        bne,
  input  logic        jump,
  input  logic        zero,
  output logic [31:0] instr_count,
  output logic [31:0] redirect_count
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    HOLD  = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [31:0] pc;
  logic [31:0] instr_q;
  logic [31:0] pc4;
  logic [31:0] br_off;
  logic [31:0] next_pc;
  logic        taken;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH:   if (imem_ack)      state_nxt = HOLD;
      HOLD:    if (instr_ready)   state_nxt = EXEC;
      EXEC:    if (resolve_valid) state_nxt = FETCH;
      default:                    state_nxt = FETCH;
    endcase
  end

  always_comb begin
    imem_req    = 1'b0;
    instr_valid = 1'b0;
    case (state)
      FETCH:   imem_req    = 1'b1;
      HOLD:    instr_valid = 1'b1;
      default: ;
    endcase
  end

  // Next-PC selection; jump overrides any branch condition.
  assign pc4     = pc + 32'd4;
  assign br_off  = {{14{instr_q[15]}}, instr_q[15:0], 2'b00};
  assign taken   = (branch & zero) | (bne & ~zero);

  always_comb begin
    next_pc = pc4;
    if (jump) begin
      next_pc = {pc4[31:28], instr_q[25:0], 2'b00};
    end else if (taken) begin
      next_pc = pc4 + br_off;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else if (state == EXEC && resolve_valid) begin
      pc <= next_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_q <= 32'd0;
    end else if (state == FETCH && imem_ack) begin
      instr_q <= imem_rdata;
    end
  end

  assign imem_addr = pc;
  assign pc_out    = pc;
  assign instr     = instr_q;
  assign opcode    = instr_q[31:26];

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] instr_cnt_q;
  logic [31:0] redirect_cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      instr_cnt_q    <= 32'd0;
      redirect_cnt_q <= 32'd0;
    end else begin
      if (state == HOLD && instr_ready) begin
        instr_cnt_q <= instr_cnt_q + 32'd1;
      end
      if (state == EXEC && resolve_valid && (jump || taken)) begin
        redirect_cnt_q <= redirect_cnt_q + 32'd1;
      end
    end
  end

  assign instr_count    = instr_cnt_q;
  assign redirect_count = redirect_cnt_q;
`else
  assign instr_count    = 32'd0;
  assign redirect_count = 32'd0;
`endif

endmodule
